// File: rtl/arb_pkg.sv
// Shared types for the split-transaction bus arbiter: FSM states, bus_sel and
// split_owner encodings.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OWN1      = 2'd1,
        OWN2      = 2'd2,
        SPLIT_RET = 2'd3
    } arb_state_t;

    localparam logic [1:0] BUS_SEL_NONE  = 2'd0;
    localparam logic [1:0] BUS_SEL_INIT1 = 2'd1;
    localparam logic [1:0] BUS_SEL_INIT2 = 2'd2;
    localparam logic [1:0] BUS_SEL_SPLIT = 2'd3;

    localparam logic [1:0] OWNER_NONE  = 2'd0;
    localparam logic [1:0] OWNER_INIT1 = 2'd1;
    localparam logic [1:0] OWNER_INIT2 = 2'd2;

endpackage

// File: rtl/arb_split_watchdog.sv
// Watchdog for a split-parked initiator: counts parked cycles outside SPLIT_RET.
// expire is combinational and fires on the edge where the count reaches SPLIT_TIMEOUT.
module arb_split_watchdog #(
    parameter int SPLIT_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic hold,
    input  logic active,
    output logic expire
);

    localparam int CW = $clog2(SPLIT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SPLIT_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPLIT_TIMEOUT - 1);

    logic [CW-1:0] cnt;
    logic          advance;

    // Saturates at CNT_MAX; a fresh park (start) restarts the count from zero.
    assign advance = active && !hold && !start && (cnt != CNT_MAX);
    assign expire  = advance && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bus_split_arbiter.sv
// Two-initiator bus arbiter with one parked split transaction and a park watchdog.
// Optional round-robin tie-break via ARB_ROUND_ROBIN_EN (fixed init1 priority otherwise).
module bus_split_arbiter
    import arb_pkg::*;
#(
    parameter int SPLIT_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init1_req,
    input  logic       init2_req,
    input  logic       split_req,
    input  logic       split_ack,
    output logic       init1_grant,
    output logic       init2_grant,
    output logic       split_grant,
    output logic [1:0] bus_sel,
    output logic [1:0] split_owner,
    output logic       split_timeout,
    output logic       busy
);

    arb_state_t state, state_nxt;
    logic [1:0] owner_fsm, owner_nxt;
    logic       park_start;
    logic       take_split;
    logic       expire;
    logic       req1_ok, req2_ok;
    logic       tie_to_init2;
    logic       wd_hold, wd_active;

    // An initiator is masked while it is the one waiting on a split return.
    assign req1_ok = init1_req && (split_owner != OWNER_INIT1);
    assign req2_ok = init2_req && (split_owner != OWNER_INIT2);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_init2;

    assign tie_to_init2 = !last_init2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_init2 <= 1'b1;
        end else if (state == IDLE && state_nxt == OWN1) begin
            last_init2 <= 1'b0;
        end else if (state == IDLE && state_nxt == OWN2) begin
            last_init2 <= 1'b1;
        end
    end
`else
    assign tie_to_init2 = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        owner_fsm  = split_owner;
        park_start = 1'b0;
        take_split = 1'b0;
        case (state)
            IDLE: begin
                if (split_req && split_owner != OWNER_NONE) begin
                    state_nxt  = SPLIT_RET;
                    take_split = 1'b1;
                end else if (req1_ok && req2_ok) begin
                    state_nxt = tie_to_init2 ? OWN2 : OWN1;
                end else if (req1_ok) begin
                    state_nxt = OWN1;
                end else if (req2_ok) begin
                    state_nxt = OWN2;
                end
            end
            OWN1: begin
                if (split_ack) begin
                    owner_fsm  = OWNER_INIT1;
                    park_start = 1'b1;
                    state_nxt  = IDLE;
                end else if (!init1_req) begin
                    state_nxt = IDLE;
                end
            end
            OWN2: begin
                if (split_ack) begin
                    owner_fsm  = OWNER_INIT2;
                    park_start = 1'b1;
                    state_nxt  = IDLE;
                end else if (!init2_req) begin
                    state_nxt = IDLE;
                end
            end
            SPLIT_RET: begin
                if (!split_req) begin
                    owner_fsm = OWNER_NONE;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Freezing the watchdog while the split return is being taken lets
    // SPLIT_RET win over a simultaneous expiry.
    assign wd_hold   = (state == SPLIT_RET) || take_split;
    assign wd_active = (split_owner != OWNER_NONE);

    arb_split_watchdog #(
        .SPLIT_TIMEOUT(SPLIT_TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .start (park_start),
        .hold  (wd_hold),
        .active(wd_active),
        .expire(expire)
    );

    always_comb begin
        owner_nxt = owner_fsm;
        if (expire) begin
            owner_nxt = OWNER_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            split_owner   <= OWNER_NONE;
            split_timeout <= 1'b0;
            init1_grant   <= 1'b0;
            init2_grant   <= 1'b0;
            split_grant   <= 1'b0;
            bus_sel       <= BUS_SEL_NONE;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            split_owner   <= owner_nxt;
            split_timeout <= expire;
            init1_grant   <= (state_nxt == OWN1);
            init2_grant   <= (state_nxt == OWN2);
            split_grant   <= (state_nxt == SPLIT_RET);
            bus_sel       <= state_nxt;
            busy          <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/bus_split_arbiter.md
BUS_SPLIT_ARBITER -- requirements
Module: bus_split_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The block SHALL have parameter SPLIT_TIMEOUT, default 65535, meaning the maximum cycles a split-parked initiator waits before its park is cancelled.
REQ-003 The block SHALL have these ports:
- clk  input  1  system clock
- rst_n  input  1  async active-low reset
- init1_req  input  1  initiator 1 bus request
- init2_req  input  1  initiator 2 bus request
- split_req  input  1  split target requests the bus to return data
- split_ack  input  1  selected target signalled split on the current transaction
- init1_grant  output  1  initiator 1 owns bus
- init2_grant  output  1  initiator 2 owns bus
- split_grant  output  1  split target owns bus
- bus_sel  output  2  0 none, 1 init1, 2 init2, 3 split return
- split_owner  output  2  parked initiator, 0 none, 1 init1, 2 init2
- split_timeout  output  1  one-cycle pulse on watchdog expiry
- busy  output  1  any grant asserted

Function
REQ-004 The arbiter SHALL implement states IDLE, OWN1, OWN2, SPLIT_RET, with all outputs registered.
REQ-005 The arbiter SHALL hold exactly one grant in OWN1, OWN2 or SPLIT_RET, and SHALL hold none in IDLE.
REQ-006 In IDLE, if split_req is high and split_owner!=0, the arbiter SHALL go to SPLIT_RET, which has the highest priority.
REQ-007 In IDLE, if split_req is not taken, the arbiter SHALL pick among the unmasked init requests; an initiator is masked while it is split_owner.
REQ-008 A grant SHALL assert on the cycle after the request is sampled in IDLE, giving one-cycle latency.
REQ-009 In OWNk, when initk_req is low, the arbiter SHALL return to IDLE and the grant SHALL drop on the next cycle.
REQ-010 In OWNk, when split_ack is high, the arbiter SHALL set split_owner=k, drop the grant, and go to IDLE.
- split_ack SHALL win over a simultaneous req deassertion.
REQ-011 In SPLIT_RET, when split_req is low, the arbiter SHALL clear split_owner and return to IDLE.
REQ-012 bus_sel SHALL equal the state encoding (IDLE 0, OWN1 1, OWN2 2, SPLIT_RET 3).
REQ-013 split_req with split_owner==0 SHALL be ignored: no grant and no error.
REQ-014 If a split_ack arrives while split_owner!=0, it SHALL overwrite split_owner; the bus allows only one outstanding split.
REQ-015 The watchdog counter SHALL be $clog2(SPLIT_TIMEOUT+1) bits wide, SHALL clear when split_owner is set, and SHALL increment each cycle while parked and not in SPLIT_RET.
REQ-016 On a watchdog count of SPLIT_TIMEOUT, the block SHALL pulse split_timeout, clear split_owner and unmask the initiator; the counter SHALL saturate, never wrap.
REQ-017 If the watchdog expires in the same cycle a split_req is taken in IDLE, SPLIT_RET SHALL win and no timeout pulse SHALL be issued.
REQ-018 A transaction in progress SHALL never be pre-empted; split_req waits until IDLE.

Reset
REQ-019 Asserting rst_n low SHALL immediately (asynchronously) force the following, including mid-transaction or mid-split:
- state IDLE
- all grants 0
- bus_sel 0
- split_owner 0
- split_timeout 0
- busy 0
- watchdog counter 0
REQ-020 The first grant after reset deassertion SHALL follow REQ-008, with no extra delay.

Configuration
REQ-021 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: init1 and init2 alternate, and the last-granted initiator loses a tie; the last-granted register resets to init2, so init1 wins the first tie.
- Undefined: init1 SHALL always win a tie (fixed priority), and no last-granted register SHALL exist.

Structure
REQ-022 Package arb_pkg SHALL hold the arb_state_t enum, the BUS_SEL_NONE/INIT1/INIT2/SPLIT constants, and the OWNER_NONE/INIT1/INIT2 constants.
REQ-023 The watchdog SHALL be the sole sub-module, arb_split_watchdog, with inputs clk, rst_n, start, hold, active and output expire.

Verification
REQ-024 The bench SHALL cover these directed scenarios, with SPLIT_TIMEOUT=16 unless stated:
- init1_req high for 5 cycles -> init1_grant high cycles 2-6, bus_sel=1, then IDLE with bus_sel=0.
- init1_req and init2_req rise together, twice: with the macro the grants are init1 then init2; without it init1 wins both.
- init1 granted and split_ack pulsed -> next cycle init1_grant=0, split_owner=1; init2_req then granted while init1_req stays high and masked.
- split_req raised 8 cycles after park, while init2 owns -> SPLIT_RET only after init2_req drops, split_grant=1, bus_sel=3, split_owner cleared when split_req drops.
- Park with no split_req -> split_timeout pulse exactly 16 cycles after park, split_owner=0, init1 granted on the next IDLE.
- rst_n pulsed low during SPLIT_RET -> all outputs 0 immediately; init2_req is granted one cycle after release.
